// File: rtl/handshake_arb_pkg.sv
// Shared helpers for the handshake constant arbiter: index-width sizing and
// output-stage state encodings.
package handshake_arb_pkg;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Bits needed to encode 0..n-1.
  function automatic int clog2_int(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

  // A single requester still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : clog2_int(n);
  endfunction

endpackage

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter: rotating pointer, rotate/priority-encode/unrotate grant,
// pointer moves past the winner only when the grant is consumed.
module handshake_rr_arbiter
  import handshake_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_WIDTH = idx_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 advance,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam logic [IDX_WIDTH:0]   NUM_REQ_W = (IDX_WIDTH + 1)'(NUM_REQ);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REQ - 1);
  localparam logic [IDX_WIDTH-1:0] ONE_IDX   = IDX_WIDTH'(1);

  logic [IDX_WIDTH-1:0] ptr_reg;
  logic [IDX_WIDTH-1:0] ptr_next;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_WIDTH-1:0] offset;
  logic [IDX_WIDTH:0]   idx_sum;

  // Doubling the vector turns the wrap-around scan into a plain right shift.
  assign req_dbl = {req, req};
  assign req_rot = NUM_REQ'(req_dbl >> ptr_reg);

  always_comb begin
    offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = IDX_WIDTH'(i);
      end
    end
  end

  assign grant_valid = |req;
  assign idx_sum     = {1'b0, ptr_reg} + {1'b0, offset};

  always_comb begin
    if (idx_sum >= NUM_REQ_W) begin
      grant_idx = IDX_WIDTH'(idx_sum - NUM_REQ_W);
    end else begin
      grant_idx = idx_sum[IDX_WIDTH-1:0];
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = grant_valid && (grant_idx == IDX_WIDTH'(gi));
  end

  // Explicit wrap keeps ptr inside 0..NUM_REQ-1 for non-power-of-two counts.
  assign ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + ONE_IDX;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= '0;
    end else if (advance && grant_valid) begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/handshake_constant_rr_arbiter.sv
// Shares one constant source among NUM_REQ control-token requesters through a
// round-robin arbiter feeding a registered single-entry elastic output stage.
module handshake_constant_rr_arbiter
  import handshake_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 37,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(37'h0AB30F6D64),
  localparam int IDX_WIDTH = idx_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_WIDTH-1:0]  outs_index,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  logic [0:0]           state_reg;
  logic [0:0]           state_next;
  logic [IDX_WIDTH-1:0] index_reg;
  logic [IDX_WIDTH-1:0] index_next;
  logic                 load;
  logic                 handshake;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic                 grant_valid;

  handshake_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (ctrl_valid),
    .advance     (handshake),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Draining and refilling in the same cycle keeps throughput at one token per cycle.
  assign load      = (state_reg == ST_EMPTY) || outs_ready;
  assign handshake = rst && load && grant_valid;
  assign ctrl_ready = handshake ? grant : '0;

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    if (handshake) begin
      state_next = ST_FULL;
      index_next = grant_idx;
    end else if (outs_ready) begin
      state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_EMPTY;
      index_reg <= '0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
    end
  end

  assign outs       = CONST_VALUE;
  assign outs_index = index_reg;
  assign outs_valid = (state_reg == ST_FULL);

endmodule

// File: tb/tb_handshake_constant_rr_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// queue-based reference model of the arbiter and its output stage.
module tb_handshake_constant_rr_arbiter;

  localparam logic [36:0] CONST37 = 37'h0AB30F6D64;
  localparam logic [15:0] CONST16 = 16'h6D64;

  logic        clk;
  logic        rst;
  logic [3:0]  ctrl_valid;
  logic [3:0]  ctrl_ready;
  logic [36:0] outs;
  logic [1:0]  outs_index;
  logic        outs_valid;
  logic        outs_ready;

  logic        rst3;
  logic [2:0]  ctrl_valid3;
  logic [2:0]  ctrl_ready3;
  logic [15:0] outs3;
  logic [1:0]  outs_index3;
  logic        outs_valid3;
  logic        outs_ready3;

  int n_cmp;
  int n_err;

  handshake_constant_rr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (37)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .outs       (outs),
    .outs_index (outs_index),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  handshake_constant_rr_arbiter #(
    .NUM_REQ    (3),
    .DATA_WIDTH (16)
  ) dut3 (
    .clk        (clk),
    .rst        (rst3),
    .ctrl_valid (ctrl_valid3),
    .ctrl_ready (ctrl_ready3),
    .outs       (outs3),
    .outs_index (outs_index3),
    .outs_valid (outs_valid3),
    .outs_ready (outs_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ctrl_valid = 4'b0000;
    outs_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // First valid requester scanning ptr, ptr+1, ... modulo 4; -1 if none.
  function automatic int pick(input int p, input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    ctrl_valid = 4'b1111;
    outs_ready = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (outs_valid !== 1'b0 || outs_index !== 2'd0 || ctrl_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_idle: valid=%b index=%0d ready=%b, want 0/0/0000", outs_valid, outs_index, ctrl_ready);
    end
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (outs_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_prefill: outs_valid=%b, want 1", outs_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (outs_valid !== 1'b0 || outs_index !== 2'd0 || ctrl_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_async: valid=%b index=%0d ready=%b, want 0/0/0000", outs_valid, outs_index, ctrl_ready);
    end
    @(negedge clk);
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctrl_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_first_grant: ctrl_ready=%b, want 0001", ctrl_ready);
    end
    tick();
    n_cmp++;
    if (outs_valid !== 1'b1 || outs_index !== 2'd0) begin
      n_err++;
      $display("FAIL reset_first_out: valid=%b index=%0d, want 1/0", outs_valid, outs_index);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_r;
    do_reset();
    ctrl_valid = 4'b1111;
    outs_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_r = 4'b0001 << (k % 4);
      @(negedge clk);
      n_cmp++;
      if (ctrl_ready !== exp_r) begin
        n_err++;
        $display("FAIL rr_ready k=%0d: got %b, want %b", k, ctrl_ready, exp_r);
      end
      tick();
      n_cmp++;
      if (outs_valid !== 1'b1 || outs_index !== 2'(k % 4) || outs !== CONST37) begin
        n_err++;
        $display("FAIL rr_out k=%0d: valid=%b index=%0d outs=%h, want 1/%0d/%h", k, outs_valid, outs_index, outs, k % 4, CONST37);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ctrl_valid = 4'b0110;
    outs_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctrl_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL bp_fill: ctrl_ready=%b, want 0010", ctrl_ready);
    end
    tick();
    outs_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ctrl_ready !== 4'b0000 || outs_index !== 2'd1 || outs_valid !== 1'b1 || outs !== CONST37) begin
        n_err++;
        $display("FAIL bp_stall k=%0d: ready=%b index=%0d valid=%b, want 0000/1/1", k, ctrl_ready, outs_index, outs_valid);
      end
      tick();
    end
    outs_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctrl_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL bp_release_ready: ctrl_ready=%b, want 0100", ctrl_ready);
    end
    tick();
    n_cmp++;
    if (outs_index !== 2'd2 || outs_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_out: index=%0d valid=%b, want 2/1", outs_index, outs_valid);
    end
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    outs_ready = 1'b1;
    ctrl_valid = 4'b0100;
    tick();
    ctrl_valid = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (ctrl_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL wrap_ready: ctrl_ready=%b, want 0001", ctrl_ready);
    end
    tick();
    n_cmp++;
    if (outs_index !== 2'd0 || outs_valid !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_out: index=%0d valid=%b, want 0/1", outs_index, outs_valid);
    end
    ctrl_valid = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if (ctrl_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL wrap_ptr: ctrl_ready=%b, want 0010", ctrl_ready);
    end
    tick();
    ctrl_valid = 4'b1001;
    @(negedge clk);
    n_cmp++;
    if (ctrl_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL wrap_skip: ctrl_ready=%b, want 1000", ctrl_ready);
    end
    tick();
    n_cmp++;
    if (outs_index !== 2'd3) begin
      n_err++;
      $display("FAIL wrap_skip_out: index=%0d, want 3", outs_index);
    end
  endtask

  task automatic test_non_pow2();
    n_cmp++;
    if (outs_valid3 !== 1'b0 || ctrl_ready3 !== 3'b000) begin
      n_err++;
      $display("FAIL np2_reset: valid=%b ready=%b, want 0/000", outs_valid3, ctrl_ready3);
    end
    rst3 = 1'b1;
    ctrl_valid3 = 3'b111;
    outs_ready3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if (outs_valid3 !== 1'b1 || outs_index3 !== 2'(k % 3) || outs3 !== CONST16) begin
        n_err++;
        $display("FAIL np2_out k=%0d: valid=%b index=%0d outs=%h, want 1/%0d/%h", k, outs_valid3, outs_index3, outs3, k % 3, CONST16);
      end
    end
  endtask

  task automatic test_random();
    int q[$];
    int wait_cnt[4];
    int m_ptr;
    int w;
    int exp_tok;
    bit load;
    logic [3:0] exp_r;
    do_reset();
    m_ptr = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      ctrl_valid = 4'($urandom);
      outs_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      load = (q.size() == 0) || outs_ready;
      w = pick(m_ptr, ctrl_valid);
      exp_r = (load && w >= 0) ? (4'b0001 << w) : 4'b0000;
      n_cmp++;
      if (ctrl_ready !== exp_r) begin
        n_err++;
        $display("FAIL rnd_ready cyc=%0d: got %b, want %b", cyc, ctrl_ready, exp_r);
      end
      n_cmp++;
      if (!$onehot0(ctrl_ready)) begin
        n_err++;
        $display("FAIL rnd_onehot cyc=%0d: ctrl_ready=%b, want at most one bit", cyc, ctrl_ready);
      end
      n_cmp++;
      if (outs_valid !== (q.size() != 0) || outs !== CONST37) begin
        n_err++;
        $display("FAIL rnd_valid cyc=%0d: valid=%b outs=%h, want %b/%h", cyc, outs_valid, outs, q.size() != 0, CONST37);
      end
      if (q.size() != 0) begin
        exp_tok = q[0];
        n_cmp++;
        if (outs_index !== 2'(exp_tok)) begin
          n_err++;
          $display("FAIL rnd_index cyc=%0d: got %0d, want %0d", cyc, outs_index, exp_tok);
        end
        if (outs_ready) void'(q.pop_front());
      end
      for (int i = 0; i < 4; i++) begin
        if (!ctrl_valid[i]) wait_cnt[i] = 0;
      end
      if (load && w >= 0) begin
        n_cmp++;
        if (wait_cnt[w] > 3) begin
          n_err++;
          $display("FAIL rnd_fair cyc=%0d: req %0d waited %0d handshakes, want <= 3", cyc, w, wait_cnt[w]);
        end
        for (int i = 0; i < 4; i++) begin
          if (i != w && ctrl_valid[i]) wait_cnt[i]++;
        end
        wait_cnt[w] = 0;
        q.push_back(w);
        m_ptr = (w + 1) % 4;
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    rst3 = 1'b0;
    ctrl_valid = 4'b0000;
    outs_ready = 1'b0;
    ctrl_valid3 = 3'b000;
    outs_ready3 = 1'b0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse_wrap();
    test_non_pow2();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/handshake_constant_rr_arbiter.md
Name: handshake_constant_rr_arbiter

Overview:
Shares one handshake constant source between NUM_REQ control-token requesters.
- Arbitrates valid control tokens round-robin and emits CONST_VALUE with the winning requester's index.
- Output is a registered single-entry elastic stage, so outs_valid, outs and outs_index come from flops and never combinationally from ctrl_valid.
- Sits in the dataflow fabric wherever several basic-block control paths trigger the same constant, replacing per-path constant copies.

Parameters:
- NUM_REQ, 4: number of requester channels, 1..16.
- DATA_WIDTH, 37: width of outs.
- CONST_VALUE, 37'h0AB30F6D64: constant driven on outs; truncated or zero-extended to DATA_WIDTH.
- IDX_WIDTH, derived as max(1, clog2(NUM_REQ)): width of outs_index. Not user-overridable.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ctrl_valid  in  NUM_REQ  per-requester token valid.
- ctrl_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- outs  out  DATA_WIDTH  constant payload.
- outs_index  out  IDX_WIDTH  index of the requester whose token produced this output.
- outs_valid  out  1  output token valid, registered.
- outs_ready  in  1  downstream accept.

Behaviour:
- Reset (rst=0, asynchronous):
  - full=0, outs_valid=0, outs_index=0, ptr=0.
  - outs is constant and unaffected by reset.
  - A token held at reset is discarded; no ctrl_ready is high while rst=0.
- Output stage states: EMPTY (full=0) and FULL (full=1). outs_valid=full.
- load = !full | outs_ready. This allows a same-cycle drain and refill, giving full throughput of 1 token/cycle.
- Grant is combinational from ctrl_valid and ptr:
  - Winner is the first i with ctrl_valid[i]=1 scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - No valid requester means no grant.
- ctrl_ready[i] = load & grant[i]. A handshake on requester i occurs when ctrl_valid[i] & ctrl_ready[i].
- On a handshake:
  - full<=1 and outs_index<=i at the next edge.
  - ptr<=(i+1) mod NUM_REQ. The wrap from NUM_REQ-1 goes to 0. For NUM_REQ not a power of two, ptr never takes values >= NUM_REQ.
- Transitions:
  - EMPTY -> FULL on a handshake.
  - FULL -> EMPTY on outs_ready with no handshake.
  - FULL -> FULL on outs_ready with a handshake (new index loaded).
  - FULL -> FULL holding on !outs_ready; outs_index and outs are stable and all ctrl_ready=0.
- ptr does not change in any cycle without a handshake, including stall cycles.
- Latency: token accepted in cycle N appears with outs_valid=1 in cycle N+1.
- Requesters need not hold ctrl_valid when not granted; the arbiter is fair only to requesters that hold valid.
- Fairness bound: a requester holding valid is granted within NUM_REQ handshakes.
- NUM_REQ=1: degenerates to a registered constant; outs_index=0 always.
- Comparable or wider DATA_WIDTH than the constant: zero-extend. Narrower: drop the MSBs.

Decomposition:
- Package handshake_arb_pkg holds the clog2-based index-width function and the max(1, ·) guard.
- One sub-module, handshake_rr_arbiter (NUM_REQ): ptr register plus rotate/priority-encode/unrotate logic.
  - Inputs: req, advance.
  - Outputs: one-hot grant, grant_idx.
  - Updates ptr only when advance=1.
- The top level owns the elastic output register and the ready/valid glue.

Test Plan:
1. Reset mid-traffic: all ctrl_valid=1, outs_ready=1, drop rst for 1 cycle while full. Required: outs_valid=0 immediately (asynchronous); after release, first grant goes to requester 0 and outs_index=0 the next cycle.
2. Round-robin: NUM_REQ=4, ctrl_valid=4'b1111, outs_ready=1 for 8 cycles. Required: outs_index sequence 0,1,2,3,0,1,2,3, one output per cycle, outs=37'h0AB30F6D64 throughout.
3. Backpressure: fill, then outs_ready=0 for 5 cycles with ctrl_valid=4'b0110. Required: ctrl_ready=0 throughout, outs_index frozen at 1, ptr unchanged; on release, next outs_index=2.
4. Sparse and wrap: ptr=3, ctrl_valid=4'b0001. Required: grant to 0 via wrap, ptr becomes 1, outs_index=0.
5. Non-power-of-two: NUM_REQ=3, all valid, 6 handshakes. Required: indices 0,1,2,0,1,2, never 3.
6. Random valids and random outs_ready, 10k cycles, with a scoreboard. Required: one-hot-or-zero ctrl_ready, no lost or duplicated tokens, per-requester wait ≤ NUM_REQ handshakes.
